// File: rtl/c16_snd.sv
// Write-only sound peripheral for the c16 CPU: per-voice square/noise tone
// generators stepped at the sample rate and mixed into one signed PCM sample.
module c16_snd #(
    parameter int VOICES     = 4,
    parameter int SAMPLE_DIV = 1134
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snd_wen,
    input  logic [1:0]  w_param,
    input  logic [10:0] w_index,
    input  logic [15:0] w_val,
    output logic [15:0] sample_out,
    output logic        sample_valid
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    localparam logic [1:0] P_PERIOD = 2'd0;
    localparam logic [1:0] P_VOL    = 2'd1;
    localparam logic [1:0] P_CTRL   = 2'd2;
    localparam logic [1:0] P_MASTER = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t state, state_nx;

    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [15:0]       period [VOICES];
    logic [15:0]       phase  [VOICES];
    logic [3:0]        vol    [VOICES];
    logic [VOICES-1:0] en, noise, level;
    logic [3:0]        master_att;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic              voice_wr;

    logic [IDX_W-1:0]  idx;
    logic              last_voice;
    logic signed [16:0] acc, acc_sum, contrib, mag;

    assign tick     = (div == DIV_W'(SAMPLE_DIV - 1));
    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign voice_wr = snd_wen && (w_param != P_MASTER) && (w_index[10:2] == '0)
                      && (32'(w_index[1:0]) < VOICES);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the voice arrays are a handful of flops, not RAM, so resetting them is cheap and required.
            for (int v = 0; v < VOICES; v++) begin
                period[v] <= '0;
                phase[v]  <= '0;
                vol[v]    <= '0;
            end
            en         <= '0;
            noise      <= '0;
            level      <= '1;
            master_att <= '0;
            lfsr       <= 16'hACE1;
        end else begin
            if (tick) begin
                lfsr <= {lfsr_fb, lfsr[15:1]};
            end
            if (snd_wen && w_param == P_MASTER) begin
                master_att <= w_val[3:0];
            end
            for (int v = 0; v < VOICES; v++) begin
                // A period write in the tick cycle owns phase/level for that voice.
                if (tick && en[v] && period[v] != '0 &&
                    !(voice_wr && w_param == P_PERIOD && w_index[1:0] == 2'(v))) begin
                    if (phase[v] == period[v] - 16'd1) begin
                        phase[v] <= '0;
                        level[v] <= noise[v] ? lfsr[0] : ~level[v];
                    end else begin
                        phase[v] <= phase[v] + 16'd1;
                    end
                end
                if (voice_wr && w_index[1:0] == 2'(v)) begin
                    case (w_param)
                        P_PERIOD: begin
                            period[v] <= w_val;
                            phase[v]  <= '0;
                            level[v]  <= 1'b1;
                        end
                        P_VOL:    vol[v] <= w_val[3:0];
                        P_CTRL: begin
                            en[v]    <= w_val[0];
                            noise[v] <= w_val[1];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mag        = {4'd0, vol[idx], 9'd0};
    assign acc_sum    = acc + contrib;
    assign last_voice = (idx == IDX_W'(VOICES - 1));

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        contrib = '0;
        if (en[idx] && period[idx] != '0 && vol[idx] != '0) begin
            contrib = level[idx] ? mag : -mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sample_valid = 1'b0;
        case (state)
            S_IDLE: if (tick) state_nx = S_ACC;
            S_ACC:  if (last_voice) state_nx = S_OUT;
            S_OUT: begin
                sample_valid = 1'b1;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Voices are summed one per cycle from live registers, so a write lands mid-mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            idx        <= '0;
            sample_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (tick) begin
                    acc <= '0;
                    idx <= '0;
                end
                S_ACC: begin
                    acc <= acc_sum;
                    idx <= idx + IDX_W'(1);
                    if (last_voice) begin
                        sample_out <= 16'(acc_sum >>> master_att);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c16_snd.sv
// Self-checking bench for c16_snd: directed scenarios plus random register
// traffic, all compared against a behavioural model of voices, LFSR and mixer.
module tb_c16_snd;

    localparam int VOICES     = 4;
    localparam int SAMPLE_DIV = 8;
    localparam logic [15:0] POS1 = 16'd7680;
    localparam logic [15:0] NEG1 = 16'hE200;

    logic        clk = 1'b0;
    logic        reset;
    logic        snd_wen;
    logic [1:0]  w_param;
    logic [10:0] w_index;
    logic [15:0] w_val;
    logic [15:0] sample_out;
    logic        sample_valid;

    int n_checks = 0;
    int n_errors = 0;

    c16_snd #(.VOICES(VOICES), .SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .snd_wen      (snd_wen),
        .w_param      (w_param),
        .w_index      (w_index),
        .w_val        (w_val),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced once per rising edge.
    int          m_period [VOICES];
    int          m_vol    [VOICES];
    int          m_phase  [VOICES];
    bit          m_en     [VOICES];
    bit          m_noise  [VOICES];
    bit          m_level  [VOICES];
    int          m_master;
    logic [15:0] m_lfsr;
    int          m_div;
    int          m_pos;
    int          m_acc;
    logic [15:0] m_sample;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int contrib(input int v);
        if (!m_en[v] || m_period[v] == 0 || m_vol[v] == 0) return 0;
        return m_level[v] ? m_vol[v] * 512 : -(m_vol[v] * 512);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_period[v] = 0; m_vol[v] = 0; m_phase[v] = 0;
            m_en[v] = 0; m_noise[v] = 0; m_level[v] = 1;
        end
        m_master = 0; m_lfsr = 16'hACE1; m_div = 0;
        m_pos = -1; m_acc = 0; m_sample = '0; m_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit tick;
        bit vwr;
        int wv;
        if (reset) begin
            model_reset();
            return;
        end
        tick    = (m_div == SAMPLE_DIV - 1);
        vwr     = snd_wen && w_param != 2'd3 && int'(w_index) < VOICES;
        wv      = int'(w_index);
        m_valid = 1'b0;
        if (m_pos >= 0) begin
            m_acc += contrib(m_pos);
            m_pos++;
            if (m_pos == VOICES) begin
                m_sample = 16'(m_acc >>> m_master);
                m_valid  = 1'b1;
                m_pos    = -1;
            end
        end
        if (tick) begin
            m_acc = 0;
            m_pos = 0;
            for (int v = 0; v < VOICES; v++) begin
                if (!(vwr && w_param == 2'd0 && wv == v) && m_en[v] && m_period[v] != 0) begin
                    if (m_phase[v] == m_period[v] - 1) begin
                        m_phase[v] = 0;
                        m_level[v] = m_noise[v] ? m_lfsr[0] : !m_level[v];
                    end else begin
                        m_phase[v]++;
                    end
                end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        if (snd_wen && w_param == 2'd3) m_master = int'(w_val[3:0]);
        if (vwr) begin
            case (w_param)
                2'd0: begin m_period[wv] = int'(w_val); m_phase[wv] = 0; m_level[wv] = 1; end
                2'd1: m_vol[wv] = int'(w_val[3:0]);
                2'd2: begin m_en[wv] = w_val[0]; m_noise[wv] = w_val[1]; end
                default: ;
            endcase
        end
        m_div = (m_div + 1) % SAMPLE_DIV;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("valid", {31'd0, sample_valid}, {31'd0, m_valid});
        check("sample", {16'd0, sample_out}, {16'd0, m_sample});
    endtask

    task automatic wr(input logic [1:0] p, input logic [10:0] idx, input logic [15:0] v);
        snd_wen = 1'b1; w_param = p; w_index = idx; w_val = v;
        step();
        snd_wen = 1'b0; w_param = '0; w_index = '0; w_val = '0;
    endtask

    task automatic wait_div(input int d);
        for (int k = 0; k < 2 * SAMPLE_DIV && m_div != d; k++) step();
    endtask

    task automatic wait_valid(output logic [15:0] s);
        bit found = 0;
        s = '0;
        for (int k = 0; k < 4 * SAMPLE_DIV && !found; k++) begin
            step();
            if (sample_valid) begin
                found = 1;
                s = sample_out;
            end
        end
        if (!found) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // From the first cycle with reset low: output 0, first pulse at cycle 12 carrying 0.
    task automatic check_after_release(input string tag);
        int cyc = 0;
        bit found = 0;
        check({tag, "_out0"}, {16'd0, sample_out}, 32'd0);
        while (!found && cyc < 40) begin
            step();
            cyc++;
            if (sample_valid) found = 1;
        end
        check({tag, "_first_valid_cycle"}, cyc, 32'd12);
        check({tag, "_first_value"}, {16'd0, sample_out}, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic [15:0] sq [4];
        logic        b;

        reset = 1'b1; snd_wen = 1'b0; w_param = '0; w_index = '0; w_val = '0;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        check_after_release("reset");

        // Single square voice; ctrl lands in the tick cycle so that tick is skipped.
        wait_div(5);
        wr(2'd0, 11'd0, 16'd2);
        wr(2'd1, 11'd0, 16'd15);
        wr(2'd2, 11'd0, 16'd1);
        for (int k = 0; k < 4; k++) wait_valid(sq[k]);
        check("square0", {16'd0, sq[0]}, {16'd0, POS1});
        check("square1", {16'd0, sq[1]}, {16'd0, POS1});
        check("square2", {16'd0, sq[2]}, {16'd0, NEG1});
        check("square3", {16'd0, sq[3]}, {16'd0, NEG1});

        // All four voices at full volume, then master attenuation and index filtering.
        for (int v = 0; v < VOICES; v++) begin
            wr(2'd0, 11'(v), 16'hFFFF);
            wr(2'd1, 11'(v), 16'd15);
            wr(2'd2, 11'(v), 16'd1);
        end
        wait_valid(s); wait_valid(s);
        check("mix_all", {16'd0, s}, 32'd30720);
        wr(2'd3, 11'd7, 16'd2);
        wait_valid(s); wait_valid(s);
        check("master2", {16'd0, s}, 32'd7680);
        wr(2'd1, 11'd1, 16'd0);
        wait_valid(s); wait_valid(s);
        check("v1_muted", {16'd0, s}, 32'd5760);
        wr(2'd1, 11'd4, 16'd0);
        wr(2'd1, 11'h404, 16'd0);
        wait_valid(s); wait_valid(s);
        check("bad_index", {16'd0, s}, 32'd5760);

        // Period write to v0 collides with the tick where v0 would wrap.
        wr(2'd3, 11'd0, 16'd0);
        wr(2'd2, 11'd2, 16'd0);
        wr(2'd2, 11'd3, 16'd0);
        wr(2'd1, 11'd0, 16'd15);
        wr(2'd1, 11'd1, 16'd8);
        wr(2'd2, 11'd0, 16'd1);
        wr(2'd2, 11'd1, 16'd1);
        wait_div(0);
        wr(2'd0, 11'd0, 16'd2);
        wr(2'd0, 11'd1, 16'd2);
        wait_div(7);
        step();
        wait_div(7);
        wr(2'd0, 11'd0, 16'd2);
        wait_valid(s);
        check("collide_t2", {16'd0, s}, 32'd3584);
        wait_valid(s);
        check("collide_t3", {16'd0, s}, 32'd3584);
        wait_valid(s);
        check("collide_t4", {16'd0, s}, 32'h0000F200);

        // Noise voice alone: every tick reloads level from the LFSR.
        wr(2'd2, 11'd0, 16'd0);
        wr(2'd2, 11'd1, 16'd0);
        wr(2'd1, 11'd2, 16'd15);
        wr(2'd0, 11'd2, 16'd1);
        wr(2'd2, 11'd2, 16'd3);
        for (int k = 0; k < 8; k++) begin
            wait_div(7);
            b = m_lfsr[0];
            wait_valid(s);
            check("noise", {16'd0, s}, {16'd0, (b ? POS1 : NEG1)});
        end

        // Reset two cycles into a mix: no pulse, everything back to reset values.
        wait_div(7);
        step();
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check_after_release("midmix");

        // Random register traffic with occasional resets.
        for (int k = 0; k < 900; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) begin
                int sel;
                snd_wen = 1'b1;
                w_param = 2'($urandom_range(0, 3));
                sel = $urandom_range(0, 7);
                if (sel < 6)       w_index = 11'($urandom_range(0, 3));
                else if (sel == 6) w_index = 11'($urandom_range(4, 7));
                else               w_index = 11'($urandom_range(0, 2047));
                if (w_param == 2'd0 && $urandom_range(0, 1) == 0)
                    w_val = 16'($urandom_range(1, 4));
                else
                    w_val = 16'($urandom);
            end else begin
                snd_wen = 1'b0;
            end
            step();
        end
        reset = 1'b0; snd_wen = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
